player_input_hub: RTL and testbench

PLAYER_INPUT_HUB -- requirements
Module: player_input_hub

---
 rtl/player_input_hub_if.sv | 19 +
 rtl/player_input_hub.sv | 197 +++++++++++++++++++
 tb/tb_player_input_hub.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/player_input_hub_if.sv
// Avalon-MM slave bus plus interrupt line of the player input hub.
interface player_input_hub_if;
    logic [2:0]  avs_address;
    logic        avs_read;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic [31:0] avs_readdata;
    logic        irq;

    modport slave (
        input  avs_address, avs_read, avs_write, avs_writedata,
        output avs_readdata, irq
    );

    modport master (
        output avs_address, avs_read, avs_write, avs_writedata,
        input  avs_readdata, irq
    );
endinterface

// File: rtl/player_input_hub.sv
// Player input hub: per-channel synchronise + debounce, lowest-channel-first
// event arbitration into a small FIFO, Avalon-MM register access and irq.

// One conduit channel: 2-flop synchroniser followed by a stability counter.
module player_input_hub_deb #(
    parameter int DATA_W          = 6,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [DATA_W-1:0] raw_i,
    output logic [DATA_W-1:0] stable_o,
    output logic              commit_o
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;

    logic [DATA_W-1:0] meta_q, sync_q, stable_q, stable_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              commit;

    // Two-flop synchroniser on the raw asynchronous inputs.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= raw_i;
            sync_q <= meta_q;
        end
    end

    // Count while the synced value differs; commit on the increment that
    // would reach DEBOUNCE_CYCLES-1, clearing the counter instead.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        commit   = 1'b0;
        if (sync_q != stable_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 2)) begin
                stable_d = sync_q;
                commit   = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Stable value and counter registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            stable_q <= '0;
            cnt_q    <= '0;
        end else begin
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stable_o = stable_q;
    assign commit_o = commit;
endmodule

module player_input_hub #(
    parameter int NUM_CH          = 4,
    parameter int DATA_W          = 6,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int FIFO_DEPTH      = 8
) (
    input  logic                     clk_clk,
    input  logic                     reset_reset_n,
    input  logic [NUM_CH*DATA_W-1:0] conduit_datac,
    player_input_hub_if.slave        avs
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [NUM_CH-1:0][DATA_W-1:0] stable;
    logic [NUM_CH-1:0]             commit;
    logic [NUM_CH-1:0]             pending_q, pending_d, gnt, mask_q, mask_d;
    logic                          push, pop, wr_en, drop, full, not_empty;
    logic [31:0]                   evt, rdata_q, rdata_d;
    logic [31:0]                   mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]              wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]              count_q, count_d;
    logic                          ovf_q, ovf_d, irq_en_q, irq_en_d, irq_q, irq_d;
    logic                          unused_wdata;

    // Write data bits above the MASK/CONTROL fields are never looked at.
    assign unused_wdata = ^avs.avs_writedata;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        player_input_hub_deb #(
            .DATA_W          (DATA_W),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_deb (
            .clk_i    (clk_clk),
            .rst_n_i  (reset_reset_n),
            .raw_i    (conduit_datac[c*DATA_W +: DATA_W]),
            .stable_o (stable[c]),
            .commit_o (commit[c])
        );
    end

    // Fixed priority: lowest-numbered pending channel builds this cycle's event.
    always_comb begin
        gnt  = '0;
        push = 1'b0;
        evt  = '0;
        for (int c = NUM_CH - 1; c >= 0; c--) begin
            if (pending_q[c]) begin
                gnt    = '0;
                gnt[c] = 1'b1;
                push   = 1'b1;
                evt    = {1'b1, 5'b0, 2'(c), 24'(stable[c])};
            end
        end
    end

    // FIFO bookkeeping, register writes, read-data mux and irq next state.
    always_comb begin
        not_empty = (count_q != '0);
        full      = (count_q == CNT_W'(FIFO_DEPTH));
        pop       = avs.avs_read && (avs.avs_address == 3'd1) && not_empty;
        wr_en     = push && (!full || pop);
        drop      = push && full && !pop;

        // A granted channel is cleared whether its event was stored or dropped.
        pending_d = (pending_q & ~gnt) | (commit & ~mask_q);

        wr_ptr_d = wr_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop   ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        if (wr_en && !pop)      count_d = count_q + 1'b1;
        else if (!wr_en && pop) count_d = count_q - 1'b1;

        mask_d   = mask_q;
        irq_en_d = irq_en_q;
        ovf_d    = ovf_q;
        if (avs.avs_write && avs.avs_address == 3'd2) begin
            irq_en_d = avs.avs_writedata[0];
            if (avs.avs_writedata[1]) ovf_d = 1'b0;
        end
        if (avs.avs_write && avs.avs_address == 3'd3) mask_d = avs.avs_writedata[NUM_CH-1:0];
        // Overflow set takes precedence over a simultaneous clear.
        if (drop) ovf_d = 1'b1;

        rdata_d = rdata_q;
        if (avs.avs_read) begin
            case (avs.avs_address)
                3'd0:    rdata_d = {17'b0, 7'(count_q), 6'b0, ovf_q, not_empty};
                3'd1:    rdata_d = not_empty ? mem_q[rd_ptr_q] : '0;
                3'd2:    rdata_d = {31'b0, irq_en_q};
                3'd3:    rdata_d = 32'(mask_q);
                default: begin
                    rdata_d = '0;
                    for (int c = 0; c < NUM_CH; c++)
                        if (avs.avs_address[1:0] == 2'(c)) rdata_d = 32'(stable[c]);
                end
            endcase
        end

        irq_d = irq_en_d & ((count_d != '0) | ovf_d);
    end

    // Control/status registers.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            pending_q <= '0;
            mask_q    <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            irq_en_q  <= 1'b0;
            irq_q     <= 1'b0;
            rdata_q   <= '0;
        end else begin
            pending_q <= pending_d;
            mask_q    <= mask_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            irq_en_q  <= irq_en_d;
            irq_q     <= irq_d;
            rdata_q   <= rdata_d;
        end
    end

    // Event storage; emptiness is tracked by count_q, so no reset needed.
    always_ff @(posedge clk_clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= evt;
    end

    assign avs.avs_readdata = rdata_q;
    assign avs.irq          = irq_q;
endmodule

// File: tb/tb_player_input_hub.sv
// Randomised scoreboard bench for player_input_hub (small debounce/FIFO build).
module tb_player_input_hub;
    localparam int NUM_CH = 4, DATA_W = 6, DEB = 4, DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [23:0] datac = '0;

    player_input_hub_if bus ();

    player_input_hub #(
        .NUM_CH (NUM_CH), .DATA_W (DATA_W), .DEBOUNCE_CYCLES (DEB), .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk_clk       (clk),
        .reset_reset_n (rst_n),
        .conduit_datac (datac),
        .avs           (bus)
    );

    always #5 clk = ~clk;

    int          n_vec = 0, n_err = 0;
    logic [31:0] exp_q [$];
    string       name_q [$];
    logic        rd_d1;
    logic [31:0] mon_e;
    string       mon_n;

    // reference model state
    logic [5:0]  raw [4];
    logic [5:0]  m_stable [4];
    logic [31:0] m_fifo [$];
    logic        m_ovf, m_irq_en;
    logic [3:0]  m_mask;

    // a read issued this cycle has data on the bus after the next edge
    always @(posedge clk or negedge rst_n)
        if (!rst_n) rd_d1 <= 1'b0;
        else        rd_d1 <= bus.avs_read;

    // monitor: pop the scoreboard whenever read data is presented
    always @(negedge clk) begin
        if (rd_d1) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_read: got %08h required nothing", bus.avs_readdata);
            end else begin
                mon_e = exp_q.pop_front();
                mon_n = name_q.pop_front();
                if (bus.avs_readdata !== mon_e) begin
                    n_err++;
                    $display("FAIL %s: got %08h required %08h", mon_n, bus.avs_readdata, mon_e);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive();
        datac = {raw[3], raw[2], raw[1], raw[0]};
    endtask

    task automatic bus_rd(input logic [2:0] a, input logic [31:0] e, input string nm);
        bus.avs_address = a;
        bus.avs_read    = 1'b1;
        exp_q.push_back(e);
        name_q.push_back(nm);
        tick(1);
        bus.avs_read = 1'b0;
    endtask

    task automatic bus_wr(input logic [2:0] a, input logic [31:0] d);
        bus.avs_address   = a;
        bus.avs_writedata = d;
        bus.avs_write     = 1'b1;
        tick(1);
        bus.avs_write = 1'b0;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] e);
        n_vec++;
        if (act !== e) begin
            n_err++;
            $display("FAIL %s: got %08h required %08h", nm, act, e);
        end
    endtask

    function automatic logic [31:0] m_status();
        return (32'(m_fifo.size()) << 8) | (32'(m_ovf) << 1) | 32'(m_fifo.size() != 0);
    endfunction

    function automatic logic [31:0] m_pop();
        if (m_fifo.size() == 0) return 32'h0;
        return m_fifo.pop_front();
    endfunction

    task automatic chk_irq(input string nm);
        chk(nm, 32'(bus.irq), 32'(m_irq_en && (m_fifo.size() != 0 || m_ovf)));
    endtask

    // Every long-held raw value that differs from the stable value becomes
    // stable; unmasked ones queue an event in channel order, dropped when full.
    task automatic m_settle();
        for (int c = 0; c < NUM_CH; c++) begin
            if (raw[c] != m_stable[c]) begin
                m_stable[c] = raw[c];
                if (!m_mask[c]) begin
                    if (m_fifo.size() < DEPTH)
                        m_fifo.push_back(32'h8000_0000 | (32'(c) << 24) | 32'(raw[c]));
                    else
                        m_ovf = 1'b1;
                end
            end
        end
    endtask

    task automatic m_reset();
        for (int c = 0; c < NUM_CH; c++) m_stable[c] = '0;
        m_fifo.delete();
        m_ovf = 1'b0; m_irq_en = 1'b0; m_mask = '0;
    endtask

    task automatic commit_phase();
        drive();
        tick(12);
        m_settle();
    endtask

    task automatic drain();
        while (m_fifo.size() != 0) bus_rd(3'd1, m_pop(), "event_drain");
        bus_rd(3'd0, m_status(), "status_drained");
    endtask

    task automatic rand_op();
        int          k, idx;
        logic [31:0] d;
        k = $urandom_range(0, 7);
        d = $urandom;
        case (k)
            0:       bus_rd(3'd0, m_status(), "status");
            1, 2:    bus_rd(3'd1, m_pop(), "event");
            3: begin
                idx = $urandom_range(0, 3);
                bus_rd(3'(4 + idx), 32'(m_stable[idx]), "stable_reg");
            end
            4: begin bus_wr(3'd3, d); m_mask = d[3:0]; end
            5: begin
                bus_wr(3'd2, d);
                m_irq_en = d[0];
                if (d[1]) m_ovf = 1'b0;
            end
            6: begin
                bus_rd(3'd2, 32'(m_irq_en), "control");
                bus_rd(3'd3, 32'(m_mask), "mask");
            end
            default: begin
                idx = $urandom_range(0, 5);
                bus_wr((idx < 2) ? 3'(idx) : 3'(idx + 2), d);
                bus_rd(3'd0, m_status(), "status_after_ignored_wr");
            end
        endcase
    endtask

    task automatic rand_round();
        int         c;
        logic [5:0] keep;
        if ($urandom_range(0, 3) == 0) begin
            c = $urandom_range(0, 3);
            keep = raw[c];
            raw[c] = 6'($urandom);
            drive();
            tick($urandom_range(1, 2));
            raw[c] = keep;
            drive();
            tick(6);
        end else begin
            for (int i = 0; i < NUM_CH; i++)
                if ($urandom_range(0, 1) == 1) raw[i] = 6'($urandom);
            commit_phase();
        end
        repeat ($urandom_range(1, 4)) rand_op();
        tick(1);
        chk_irq("irq_rand");
    endtask

    initial begin
        bus.avs_address = '0; bus.avs_read = 1'b0; bus.avs_write = 1'b0; bus.avs_writedata = '0;
        for (int c = 0; c < NUM_CH; c++) raw[c] = '0;
        m_reset();
        drive();
        #23 rst_n = 1'b1;
        tick(2);

        // reset state
        chk_irq("irq_reset");
        bus_rd(3'd0, m_status(), "status_reset");
        bus_rd(3'd2, 32'h0, "control_reset");
        bus_rd(3'd3, 32'h0, "mask_reset");
        for (int a = 4; a < 8; a++) bus_rd(3'(a), 32'h0, "stable_reset");
        bus_rd(3'd1, 32'h0, "event_empty");

        // ch0 commit timing and irq
        bus_wr(3'd2, 32'h1); m_irq_en = 1'b1;
        raw[0] = 6'h2A; drive();
        tick(5);
        chk("irq_before_push", 32'(bus.irq), 32'h0);
        tick(1);
        chk("irq_after_push", 32'(bus.irq), 32'h1);
        tick(6);
        m_settle();
        bus_rd(3'd1, m_pop(), "event_ch0");
        bus_rd(3'd0, m_status(), "status_after_pop");
        tick(1);
        chk_irq("irq_after_pop");

        // 2-clock glitch on ch1 is filtered
        raw[1] = 6'h01; drive(); tick(2);
        raw[1] = 6'h00; drive(); tick(10);
        bus_rd(3'd0, m_status(), "status_glitch");
        bus_rd(3'd5, 32'(m_stable[1]), "stable_ch1_glitch");

        // ch0 and ch3 in the same cycle
        raw[0] = 6'h15; raw[3] = 6'h3F; commit_phase();
        bus_rd(3'd0, m_status(), "status_two");
        bus_rd(3'd1, m_pop(), "event_first_ch0");
        bus_rd(3'd1, m_pop(), "event_second_ch3");

        // overflow
        for (int v = 5; v < 10; v++) begin raw[1] = 6'(v); commit_phase(); end
        bus_rd(3'd0, m_status(), "status_ovf");
        tick(1); chk_irq("irq_ovf");
        bus_wr(3'd2, 32'h3); m_ovf = 1'b0;
        bus_rd(3'd0, m_status(), "status_ovf_cleared");
        bus_rd(3'd2, 32'(m_irq_en), "control_bit1_reads0");
        drain();

        // masked channel
        bus_wr(3'd3, 32'h2); m_mask = 4'h2;
        raw[1] = 6'h33; commit_phase();
        bus_rd(3'd5, 32'(m_stable[1]), "stable_ch1_masked");
        bus_rd(3'd0, m_status(), "status_masked");
        bus_rd(3'd3, 32'h2, "mask_rb");
        bus_wr(3'd3, 32'h0); m_mask = 4'h0;

        // reset mid-debounce on ch2
        for (int c = 0; c < NUM_CH; c++) raw[c] = '0;
        commit_phase();
        drain();
        tick(2);
        raw[2] = 6'h11; drive();
        tick(4);
        #2 rst_n = 1'b0;
        #15 rst_n = 1'b1;
        m_reset();
        tick(1);
        chk_irq("irq_post_reset");
        bus_rd(3'd0, m_status(), "status_post_reset");
        bus_rd(3'd6, 32'h0, "stable_ch2_early");
        bus_rd(3'd6, 32'h0, "stable_ch2_window");
        tick(8);
        m_settle();
        bus_rd(3'd6, 32'(m_stable[2]), "stable_ch2_late");
        bus_rd(3'd0, m_status(), "status_ch2_event");
        bus_rd(3'd1, m_pop(), "event_ch2");

        // randomised traffic
        for (int r = 0; r < 60; r++) rand_round();
        drain();

        tick(3);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
